// File: rtl/rv32i_pkg.sv
// RV32I shared decode definitions.
// Opcodes, funct3 values, ALU ops, immediate formats and control bundle.
package rv32i_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_PASSB = 4'd10
  } alu_op_t;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_fmt_t;

  typedef struct packed {
    logic     reg_write;
    logic     mem_read;
    logic     mem_write;
    logic     branch;
    logic     jump;
    logic     alu_src;
    logic     illegal;
    logic     use_rs1;
    logic     use_rs2;
    alu_op_t  alu_op;
    imm_fmt_t fmt;
  } ctrl_t;

  // SUB exists only for register-register ops; SRA for both.
  function automatic alu_op_t alu_from_f3(
    input logic [2:0] f3,
    input logic       b30,
    input logic       sub_ok
  );
    alu_op_t op;
    case (f3)
      F3_ADD:  op = (sub_ok && b30) ? ALU_SUB : ALU_ADD;
      F3_SLL:  op = ALU_SLL;
      F3_SLT:  op = ALU_SLT;
      F3_SLTU: op = ALU_SLTU;
      F3_XOR:  op = ALU_XOR;
      F3_SR:   op = b30 ? ALU_SRA : ALU_SRL;
      F3_OR:   op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/imm_gen_32i.sv
// RV32I immediate generator.
// Builds I/S/B/U/J immediates and sign-extends them to dataW.
module imm_gen_32i #(
  parameter int dataW = 32
) (
  input  logic [31:7]      instr,
  input  logic [2:0]       fmt,
  output logic [dataW-1:0] imm
);
  import rv32i_pkg::*;

  logic [31:0] raw;

  always_comb begin
    raw = '0;
    case (imm_fmt_t'(fmt))
      IMM_I: raw = {{20{instr[31]}}, instr[31:20]};
      IMM_S: raw = {{20{instr[31]}}, instr[31:25],
                    instr[11:7]};
      IMM_B: raw = {{19{instr[31]}}, instr[31], instr[7],
                    instr[30:25], instr[11:8], 1'b0};
      IMM_U: raw = {instr[31:12], 12'h000};
      IMM_J: raw = {{11{instr[31]}}, instr[31],
                    instr[19:12], instr[20],
                    instr[30:21], 1'b0};
      default: raw = '0;
    endcase
  end

  assign imm = dataW'($signed(raw));

endmodule

// File: rtl/decode_32i.sv
// RV32I decode stage with pending-write scoreboard.
// Single registered output slot behind a valid/ready handshake.
module decode_32i #(
  parameter int dataW = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [31:0]      InstrIn,
  input  logic [dataW-1:0] InstrPC,
  input  logic             InstrValid,
  output logic             InstrReady,
  output logic             DecValid,
  input  logic             DecReady,
  output logic [4:0]       RegData1,
  output logic [4:0]       RegData2,
  output logic [4:0]       DecRd,
  output logic             DecRegWrite,
  output logic             DecMemRead,
  output logic             DecMemWrite,
  output logic             DecBranch,
  output logic             DecJump,
  output logic             DecAluSrc,
  output logic             DecIllegal,
  output logic [3:0]       DecAluOp,
  output logic [dataW-1:0] DecImm,
  output logic [dataW-1:0] DecPC,
  input  logic             WbValid,
  input  logic [4:0]       WbRd,
  input  logic             Flush
);
  import rv32i_pkg::*;

  logic [6:0] opcode;
  logic [4:0] rd;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic [2:0] f3;
  logic       b30;
  logic       rd_nz;

  assign opcode = InstrIn[6:0];
  assign rd     = InstrIn[11:7];
  assign f3     = InstrIn[14:12];
  assign rs1    = InstrIn[19:15];
  assign rs2    = InstrIn[24:20];
  assign b30    = InstrIn[30];
  assign rd_nz  = (rd != 5'd0);

  ctrl_t ctrl;

  always_comb begin
    ctrl         = '0;
    ctrl.alu_op  = ALU_ADD;
    ctrl.fmt     = IMM_NONE;
    ctrl.use_rs1 = 1'b1;
    unique case (opcode)
      OPC_LUI: begin
        ctrl.reg_write = rd_nz;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_op    = ALU_PASSB;
        ctrl.fmt       = IMM_U;
        ctrl.use_rs1   = 1'b0;
      end
      OPC_AUIPC: begin
        ctrl.reg_write = rd_nz;
        ctrl.alu_src   = 1'b1;
        ctrl.fmt       = IMM_U;
        ctrl.use_rs1   = 1'b0;
      end
      OPC_JAL: begin
        ctrl.reg_write = rd_nz;
        ctrl.jump      = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.fmt       = IMM_J;
        ctrl.use_rs1   = 1'b0;
      end
      OPC_JALR: begin
        ctrl.reg_write = rd_nz;
        ctrl.jump      = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.fmt       = IMM_I;
      end
      OPC_BRANCH: begin
        ctrl.branch  = 1'b1;
        ctrl.alu_op  = ALU_SUB;
        ctrl.fmt     = IMM_B;
        ctrl.use_rs2 = 1'b1;
      end
      OPC_LOAD: begin
        ctrl.reg_write = rd_nz;
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.fmt       = IMM_I;
      end
      OPC_STORE: begin
        ctrl.mem_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.fmt       = IMM_S;
        ctrl.use_rs2   = 1'b1;
      end
      OPC_OP_IMM: begin
        ctrl.reg_write = rd_nz;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_op    = alu_from_f3(f3, b30, 1'b0);
        ctrl.fmt       = IMM_I;
      end
      OPC_OP: begin
        ctrl.reg_write = rd_nz;
        ctrl.alu_op    = alu_from_f3(f3, b30, 1'b1);
        ctrl.use_rs2   = 1'b1;
      end
      OPC_FENCE: begin
        ctrl.use_rs1 = 1'b1;
      end
      default: begin
        ctrl.illegal = 1'b1;
      end
    endcase
  end

  logic [dataW-1:0] imm;

  imm_gen_32i #(
    .dataW(dataW)
  ) u_imm (
    .instr(InstrIn[31:7]),
    .fmt  (ctrl.fmt),
    .imm  (imm)
  );

  logic [31:0] sb_q;
  logic [31:0] sb_d;
  logic [31:0] clr_vec;
  logic [31:0] set_vec;
  logic [31:0] sb_live;
  logic        accept;
  logic        handoff;
  logic        rs1_hit;
  logic        rs2_hit;
  logic        hazard;

  assign accept  = InstrValid & InstrReady;
  assign handoff = DecValid & DecReady;

  always_comb begin
    clr_vec = '0;
    if (WbValid) clr_vec[WbRd] = 1'b1;
  end

  assign sb_live = sb_q & ~clr_vec;

  // The held instruction has not reached the scoreboard yet.
  assign rs1_hit = ctrl.use_rs1 && (rs1 != 5'd0) &&
                   (sb_live[rs1] ||
                    (DecValid && DecRegWrite && DecRd == rs1));
  assign rs2_hit = ctrl.use_rs2 && (rs2 != 5'd0) &&
                   (sb_live[rs2] ||
                    (DecValid && DecRegWrite && DecRd == rs2));
  assign hazard  = rs1_hit | rs2_hit;

  assign InstrReady = (~DecValid | DecReady) & ~hazard
                      & ~Flush & ~reset;

  always_comb begin
    set_vec = '0;
    if (handoff && !Flush && DecRegWrite) set_vec[DecRd] = 1'b1;
  end

  // Set after clear so a same-cycle set of the same bit wins.
  assign sb_d = (sb_live | set_vec) & ~32'd1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sb_q <= '0;
    end else begin
      sb_q <= sb_d;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      DecValid    <= 1'b0;
      RegData1    <= '0;
      RegData2    <= '0;
      DecRd       <= '0;
      DecRegWrite <= 1'b0;
      DecMemRead  <= 1'b0;
      DecMemWrite <= 1'b0;
      DecBranch   <= 1'b0;
      DecJump     <= 1'b0;
      DecAluSrc   <= 1'b0;
      DecIllegal  <= 1'b0;
      DecAluOp    <= '0;
      DecImm      <= '0;
      DecPC       <= '0;
    end else if (Flush) begin
      DecValid <= 1'b0;
    end else if (accept) begin
      DecValid    <= 1'b1;
      RegData1    <= rs1;
      RegData2    <= rs2;
      DecRd       <= rd;
      DecRegWrite <= ctrl.reg_write;
      DecMemRead  <= ctrl.mem_read;
      DecMemWrite <= ctrl.mem_write;
      DecBranch   <= ctrl.branch;
      DecJump     <= ctrl.jump;
      DecAluSrc   <= ctrl.alu_src;
      DecIllegal  <= ctrl.illegal;
      DecAluOp    <= ctrl.alu_op;
      DecImm      <= imm;
      DecPC       <= InstrPC;
    end else if (handoff) begin
      DecValid <= 1'b0;
    end
  end

endmodule

// File: doc/decode_32i.md
DECODE_32I -- requirements
Module: decode_32i

Interface
REQ-001 Parameter dataW, 32, datapath width of PC/immediate outputs.
REQ-002 Port clock  input  1  single clock; all state updates on rising edge.
REQ-003 Port reset  input  1  asynchronous, active-high reset.
REQ-004 Port InstrIn / InstrPC  input  32 / dataW  fetched instruction word and its PC.
REQ-005 Port InstrValid / InstrReady  input / output  1 / 1  upstream valid/ready handshake.
REQ-006 Port DecValid / DecReady  output / input  1 / 1  downstream valid/ready handshake.
REQ-007 Port RegData1, RegData2  output  5 each  source register read addresses to the register file (zero-extended to dataW at top level).
REQ-008 Port DecRd  output  5  destination register.
REQ-009 Port DecRegWrite, DecMemRead, DecMemWrite, DecBranch, DecJump, DecAluSrc, DecIllegal  output  1 each  control flags.
REQ-010 Port DecAluOp  output  4  ALU operation code from the shared package.
REQ-011 Port DecImm / DecPC  output  dataW / dataW  sign-extended immediate and the instruction's PC.
REQ-012 Port WbValid / WbRd  input  1 / 5  write-back completion clearing the scoreboard.
REQ-013 Port Flush  input  1  discard the held decoded instruction.

Function
REQ-014 Output register is single-entry; all Dec*/RegData* outputs are registered, 1-cycle latency from upstream accept.
REQ-015 Upstream accept = InstrValid & InstrReady; downstream handoff = DecValid & DecReady.
REQ-016 InstrReady = (~DecValid | DecReady) & ~hazard & ~Flush, combinational.
REQ-017 DecValid and all outputs hold stable while DecValid & ~DecReady.
REQ-018 Decode opcodes: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP; FENCE is a NOP (DecRegWrite=0, DecIllegal=0); any other opcode, incl. SYSTEM, sets DecIllegal=1 with DecRegWrite=DecMemRead=DecMemWrite=DecBranch=DecJump=0.
REQ-019 Immediates: I, S, B, U, J formats, bit 31 sign-extended to dataW; B/J bit 0 = 0; R-type DecImm=0.
REQ-020 DecAluOp: OP/OP-IMM from funct3 plus funct7[5] (SUB only for OP, SRA for both); LOAD/STORE/JALR/AUIPC = ADD; BRANCH = SUB; LUI = PASSB.
REQ-021 DecRegWrite=1 only for LUI, AUIPC, JAL, JALR, LOAD, OP-IMM, OP with rd!=0.
REQ-022 Scoreboard: 32-bit pending-write vector; bit rd set on handoff when DecRegWrite=1; bit WbRd cleared when WbValid; bit 0 never set.
REQ-023 Same-cycle set and clear of same bit: set wins.
REQ-024 hazard = any used source (rs1 unless LUI/AUIPC/JAL; rs2 only for BRANCH/STORE/OP), nonzero, whose scoreboard bit is set and not cleared this cycle, or equals DecRd of the held instruction with DecRegWrite=1.
REQ-025 Flush clears DecValid next edge, sets no scoreboard bit, blocks accept that cycle; scoreboard otherwise unchanged.

Reset
REQ-026 Reset asserted: DecValid=0, scoreboard=0, every registered output 0, InstrReady=0; takes effect immediately, independent of clock.
REQ-027 Reset mid-handshake discards the held instruction; first accept possible on the first edge after deassertion.

Structure
REQ-028 Shared package rv32i_pkg holds opcode constants, funct3 values, the 4-bit alu_op_t enum (ADD,SUB,SLL,SLT,SLTU,XOR,SRL,SRA,OR,AND,PASSB) and imm-format enum.
REQ-029 Sub-module imm_gen_32i (combinational immediate generator); decode, scoreboard and handshake stay in decode_32i.

Verification
REQ-030 ADDI x1,x0,5 (0x00500093), DecReady=1 -> next cycle DecValid=1, DecRd=1, DecImm=5, DecAluOp=ADD, DecAluSrc=1, DecRegWrite=1, RegData1=0.
REQ-031 ADD x3,x1,x2 immediately after x1 handoff, no WbValid -> InstrReady=0 until WbValid with WbRd=1, accepted that same cycle.
REQ-032 DecReady=0 for 3 cycles with BEQ held -> outputs stable, InstrReady=0; BEQ x0,x0,-4 gives DecImm=0xFFFFFFFC, DecAluOp=SUB, DecBranch=1.
REQ-033 Opcode 0x73 (ECALL) -> DecIllegal=1, DecRegWrite=0, no scoreboard bit set after handoff.
REQ-034 Flush while LW x5 held -> DecValid=0 next cycle, scoreboard bit 5 clear, following ADD x6,x5,x0 accepted without stall.
REQ-035 Reset asserted between clock edges while DecValid=1 -> DecValid and scoreboard 0 before next edge.
